// File: rtl/mac_fmap_feeder.sv
// mac_fmap_feeder: replays each pixel's fmap words once per output-channel group into the MAC array
module mac_fmap_feeder #(
  parameter int LANES   = 10,
  parameter int BEATS   = 4,
  parameter int REPEATS = 5,
  parameter int PIXELS  = 1024,
  parameter int ADDR_W  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic                 fmap_rd_en,
  output logic [ADDR_W-1:0]    fmap_rd_addr,
  input  logic [LANES*8-1:0]   fmap_rd_data,
  output logic [LANES*8-1:0]   MAC_data_in,
  output logic                 MAC_data_in_valid,
  output logic                 adder_rst,
  output logic [2:0]           param_sel,
  output logic [1:0]           param_beat,
  output logic                 group_last
);
  localparam int PW = PIXELS > 1 ? $clog2(PIXELS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [2:0] rep_q, rep_d;
  logic [1:0] beat_q, beat_d;
  logic drain_q, drain_d;
  logic issue, beat_wrap, rep_wrap, pix_wrap;
  logic v1_q, v1_d, rst1_q, rst1_d, last1_q, last1_d;
  logic [2:0] sel1_q, sel1_d;
  logic [1:0] beat1_q, beat1_d;
  logic valid_q, valid_d, adder_rst_q, adder_rst_d, group_last_q, group_last_d;
  logic [2:0] param_sel_q, param_sel_d;
  logic [1:0] param_beat_q, param_beat_d;
  logic [LANES*8-1:0] data_q, data_d;
  assign issue      = state_q == RUN && !stall;
  assign beat_wrap  = beat_q == 2'(BEATS - 1);
  assign rep_wrap   = rep_q == 3'(REPEATS - 1);
  assign pix_wrap   = pix_q == PW'(PIXELS - 1);
  assign busy       = state_q == RUN || state_q == DRAIN;
  assign done       = state_q == DONE;
  assign fmap_rd_en = issue;
  assign fmap_rd_addr = ADDR_W'(pix_q) * ADDR_W'(BEATS) + ADDR_W'(beat_q);
  assign MAC_data_in       = data_q;
  assign MAC_data_in_valid = valid_q;
  assign adder_rst         = adder_rst_q;
  assign param_sel         = param_sel_q;
  assign param_beat        = param_beat_q;
  assign group_last        = group_last_q;
  // Next state and beat/repeat/pixel counters; all counters wrap to 0 on the final issue
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    rep_d   = rep_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        pix_d   = '0;
        rep_d   = '0;
        beat_d  = '0;
      end
      RUN: if (issue) begin
        beat_d = beat_wrap ? 2'd0 : beat_q + 2'd1;
        rep_d  = beat_wrap ? (rep_wrap ? 3'd0 : rep_q + 3'd1) : rep_q;
        pix_d  = beat_wrap && rep_wrap ? (pix_wrap ? '0 : pix_q + 1'b1) : pix_q;
        state_d = beat_wrap && rep_wrap && pix_wrap ? DRAIN : RUN;
        drain_d = 1'b0;
      end
      DRAIN: begin
        drain_d = ~drain_q;
        state_d = drain_q ? DONE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  // Two-stage sideband pipeline so beat tags line up with the registered RAM word
  always_comb begin
    v1_d         = issue;
    rst1_d       = issue && beat_q == 2'd0;
    last1_d      = issue && beat_wrap;
    sel1_d       = issue ? rep_q : 3'd0;
    beat1_d      = issue ? beat_q : 2'd0;
    valid_d      = v1_q;
    adder_rst_d  = rst1_q;
    group_last_d = last1_q;
    param_sel_d  = sel1_q;
    param_beat_d = beat1_q;
    data_d       = v1_q ? fmap_rd_data : data_q;
  end
  // State, counters and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pix_q        <= '0;
      rep_q        <= '0;
      beat_q       <= '0;
      drain_q      <= 1'b0;
      v1_q         <= 1'b0;
      rst1_q       <= 1'b0;
      last1_q      <= 1'b0;
      sel1_q       <= '0;
      beat1_q      <= '0;
      valid_q      <= 1'b0;
      adder_rst_q  <= 1'b0;
      group_last_q <= 1'b0;
      param_sel_q  <= '0;
      param_beat_q <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      rep_q        <= rep_d;
      beat_q       <= beat_d;
      drain_q      <= drain_d;
      v1_q         <= v1_d;
      rst1_q       <= rst1_d;
      last1_q      <= last1_d;
      sel1_q       <= sel1_d;
      beat1_q      <= beat1_d;
      valid_q      <= valid_d;
      adder_rst_q  <= adder_rst_d;
      group_last_q <= group_last_d;
      param_sel_q  <= param_sel_d;
      param_beat_q <= param_beat_d;
      data_q       <= data_d;
    end
  end
endmodule
